// File: rtl/stack_mem_stage.sv
// stack_mem_stage: memory stage owning data memory and SP; 32-bit accesses split into two 16-bit beats
module stack_mem_stage #(
    parameter int ADDR_W = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_is_stack,
    input  logic              i_en32,
    input  logic [3:0]        i_wb,
    input  logic [2:0]        i_rdst,
    input  logic [15:0]       i_alu,
    input  logic [31:0]       i_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [3:0]        o_wb,
    output logic [2:0]        o_rdst,
    output logic [15:0]       o_alu,
    output logic [31:0]       o_mem_data,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_stack_wrap
);
    typedef enum logic {IDLE, BEAT2} stateT;
    stateT state, nextState;
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] sp, spNext, addr;
    logic lWrite, lStack;
    logic [3:0] lWb;
    logic [2:0] lRdst;
    logic [15:0] lAlu, curAlu, firstHalf, rdWord, wrWord;
    logic [31:0] lData, curData;
    logic beat2, memOp, doWrite, doRead, curStack, wide, spWrap;
    assign o_sp = sp;
    // Each beat behaves like a 16-bit op; beat 2 replays the latched instruction against the updated SP.
    always_comb begin
        beat2 = state == BEAT2;
        memOp = beat2 | (i_valid & (i_mem_read | i_mem_write));
        doWrite = memOp & (beat2 ? lWrite : i_mem_write);
        doRead = memOp & ~doWrite;
        curStack = beat2 ? lStack : i_is_stack;
        curAlu = beat2 ? lAlu : i_alu;
        curData = beat2 ? lData : i_data;
        wide = beat2 | (memOp & i_en32);
        o_stall = ~rst & ~beat2 & memOp & i_en32;
        addr = curStack ? (doWrite ? sp : sp + 1'b1) : curAlu[ADDR_W-1:0] + ADDR_W'(beat2);
        wrWord = (wide & ~beat2) ? curData[31:16] : curData[15:0];
        rdWord = mem[addr];
        spNext = ~(memOp & curStack) ? sp : doWrite ? sp - 1'b1 : sp + 1'b1;
        spWrap = memOp & curStack & (doWrite ? sp == '0 : sp == '1);
        nextState = o_stall ? BEAT2 : IDLE;
    end
    always_ff @(posedge clk) state <= nextState;
    always_ff @(posedge clk) if (~rst & doWrite) mem[addr] <= wrWord;
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= SP_RESET;
            o_valid <= 1'b0;
            o_wb <= '0;
            o_rdst <= '0;
            o_alu <= '0;
            o_mem_data <= '0;
            o_stack_wrap <= 1'b0;
        end else begin
            sp <= spNext;
            o_stack_wrap <= spWrap;
            o_valid <= beat2 | (i_valid & ~o_stall);
            if (o_stall) begin
                lWrite <= i_mem_write;
                lStack <= i_is_stack;
                lAlu <= i_alu;
                lData <= i_data;
                lWb <= i_wb;
                lRdst <= i_rdst;
                firstHalf <= rdWord;
            end else if (beat2 | i_valid) begin
                o_wb <= beat2 ? lWb : i_wb;
                o_rdst <= beat2 ? lRdst : i_rdst;
                o_alu <= curAlu;
                o_mem_data <= ~doRead ? '0 : ~beat2 ? {16'h0, rdWord} :
                              curStack ? {rdWord, firstHalf} : {firstHalf, rdWord};
            end
        end
    end
endmodule

// File: tb/tb_stack_mem_stage.sv
// tb_stack_mem_stage: directed tests of stack_mem_stage with hand-computed expectations
module tb_stack_mem_stage;
    logic clk, rst, i_valid, i_mem_read, i_mem_write, i_is_stack, i_en32;
    logic [3:0] i_wb;
    logic [2:0] i_rdst;
    logic [15:0] i_alu;
    logic [31:0] i_data;
    logic o_stall, o_valid, o_stack_wrap;
    logic [3:0] o_wb;
    logic [2:0] o_rdst;
    logic [15:0] o_alu;
    logic [31:0] o_mem_data;
    logic [10:0] o_sp;
    int vectors = 0;
    int miscompares = 0;

    stack_mem_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_is_stack(i_is_stack), .i_en32(i_en32),
        .i_wb(i_wb), .i_rdst(i_rdst), .i_alu(i_alu), .i_data(i_data),
        .o_stall(o_stall), .o_valid(o_valid), .o_wb(o_wb), .o_rdst(o_rdst),
        .o_alu(o_alu), .o_mem_data(o_mem_data), .o_sp(o_sp), .o_stack_wrap(o_stack_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, rd, wr, st, e32, input logic [15:0] alu, input logic [31:0] data);
        i_valid = v; i_mem_read = rd; i_mem_write = wr; i_is_stack = st; i_en32 = e32;
        i_alu = alu; i_data = data; i_wb = 4'h0; i_rdst = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 1, 1, 1, 16'h0, 32'hFFFF_FFFF);
        #1;
        vectors++; if (o_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        tick(); tick();
        vectors++; if (o_sp !== 11'd2047) begin miscompares++; $display("FAIL reset_sp: got %0d expected 2047", o_sp); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        vectors++; if (o_mem_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", o_mem_data); end
        vectors++; if (o_stack_wrap !== 1'b0 || o_wb !== 4'h0 || o_rdst !== 3'd0 || o_alu !== 16'h0) begin
            miscompares++; $display("FAIL reset_outs: got wrap=%b wb=%h rdst=%h alu=%h expected all 0", o_stack_wrap, o_wb, o_rdst, o_alu); end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0);
        tick();
    endtask

    task automatic test_push16();
        drive(1, 0, 1, 1, 0, 16'h1234, 32'h0000_ABCD);
        i_wb = 4'h9; i_rdst = 3'd5;
        #1;
        vectors++; if (o_stall !== 1'b0) begin miscompares++; $display("FAIL push16_stall: got %b expected 0", o_stall); end
        tick();
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL push16_valid: got %b expected 1", o_valid); end
        vectors++; if (o_sp !== 11'd2046) begin miscompares++; $display("FAIL push16_sp: got %0d expected 2046", o_sp); end
        vectors++; if (o_wb !== 4'h9 || o_rdst !== 3'd5 || o_alu !== 16'h1234) begin
            miscompares++; $display("FAIL push16_pass: got wb=%h rdst=%h alu=%h expected 9 5 1234", o_wb, o_rdst, o_alu); end
        vectors++; if (o_stack_wrap !== 1'b0 || o_mem_data !== 32'h0) begin
            miscompares++; $display("FAIL push16_misc: got wrap=%b data=%h expected 0 0", o_stack_wrap, o_mem_data); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0);
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", o_valid); end
        drive(1, 1, 0, 1, 0, 16'h0, 32'h0);
        tick();
        vectors++; if (o_mem_data !== 32'h0000_ABCD) begin miscompares++; $display("FAIL push16_readback: got %h expected 0000abcd", o_mem_data); end
        vectors++; if (o_sp !== 11'd2047) begin miscompares++; $display("FAIL push16_popsp: got %0d expected 2047", o_sp); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0);
        tick();
    endtask

    task automatic test_roundtrip();
        drive(1, 0, 1, 1, 0, 16'h0, 32'h0000_1111); tick();
        drive(1, 0, 1, 1, 0, 16'h0, 32'h0000_2222); tick();
        vectors++; if (o_sp !== 11'd2045) begin miscompares++; $display("FAIL rt_sp_after_push: got %0d expected 2045", o_sp); end
        drive(1, 1, 0, 1, 0, 16'h0, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_2222) begin miscompares++; $display("FAIL rt_pop1: got %h expected 00002222", o_mem_data); end
        tick();
        vectors++; if (o_mem_data !== 32'h0000_1111) begin miscompares++; $display("FAIL rt_pop2: got %h expected 00001111", o_mem_data); end
        vectors++; if (o_sp !== 11'd2047) begin miscompares++; $display("FAIL rt_sp: got %0d expected 2047", o_sp); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
    endtask

    task automatic test_push32_pop32();
        drive(1, 0, 1, 1, 1, 16'h0, 32'h0001_0030);
        #1;
        vectors++; if (o_stall !== 1'b1) begin miscompares++; $display("FAIL push32_stall1: got %b expected 1", o_stall); end
        tick();
        vectors++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
            miscompares++; $display("FAIL push32_beat2: got valid=%b stall=%b expected 0 0", o_valid, o_stall); end
        vectors++; if (o_sp !== 11'd2046) begin miscompares++; $display("FAIL push32_sp_mid: got %0d expected 2046", o_sp); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_sp !== 11'd2045) begin
            miscompares++; $display("FAIL push32_done: got valid=%b sp=%0d expected 1 2045", o_valid, o_sp); end
        drive(1, 1, 0, 0, 0, 16'd2047, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_0001) begin miscompares++; $display("FAIL push32_mem2047: got %h expected 00000001", o_mem_data); end
        drive(1, 1, 0, 0, 0, 16'd2046, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_0030) begin miscompares++; $display("FAIL push32_mem2046: got %h expected 00000030", o_mem_data); end
        drive(1, 1, 0, 1, 1, 16'h0, 32'h0);
        #1;
        vectors++; if (o_stall !== 1'b1) begin miscompares++; $display("FAIL pop32_stall1: got %b expected 1", o_stall); end
        tick();
        vectors++; if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_sp !== 11'd2046) begin
            miscompares++; $display("FAIL pop32_beat2: got valid=%b stall=%b sp=%0d expected 0 0 2046", o_valid, o_stall, o_sp); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_mem_data !== 32'h0001_0030) begin
            miscompares++; $display("FAIL pop32_data: got valid=%b data=%h expected 1 00010030", o_valid, o_mem_data); end
        vectors++; if (o_sp !== 11'd2047) begin miscompares++; $display("FAIL pop32_sp: got %0d expected 2047", o_sp); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
    endtask

    task automatic test_nonstack();
        drive(1, 0, 1, 0, 0, 16'h0010, 32'h0000_BEEF); tick();
        vectors++; if (o_valid !== 1'b1 || o_mem_data !== 32'h0) begin
            miscompares++; $display("FAIL ns_write: got valid=%b data=%h expected 1 0", o_valid, o_mem_data); end
        drive(1, 1, 0, 0, 0, 16'h0010, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_BEEF) begin miscompares++; $display("FAIL ns_read: got %h expected 0000beef", o_mem_data); end
        drive(1, 0, 1, 0, 1, 16'h0020, 32'hDEAD_C0DE); tick(); tick();
        drive(1, 1, 0, 0, 0, 16'h0020, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_DEAD) begin miscompares++; $display("FAIL ns32_hi: got %h expected 0000dead", o_mem_data); end
        drive(1, 1, 0, 0, 0, 16'h0021, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_C0DE) begin miscompares++; $display("FAIL ns32_lo: got %h expected 0000c0de", o_mem_data); end
        drive(1, 1, 0, 0, 1, 16'h0020, 32'h0); tick(); tick();
        vectors++; if (o_mem_data !== 32'hDEAD_C0DE) begin miscompares++; $display("FAIL ns32_read: got %h expected deadc0de", o_mem_data); end
        drive(1, 1, 1, 0, 0, 16'h0030, 32'h0000_1234); tick();
        vectors++; if (o_mem_data !== 32'h0 || o_sp !== 11'd2047) begin
            miscompares++; $display("FAIL prio_write: got data=%h sp=%0d expected 0 2047", o_mem_data, o_sp); end
        drive(1, 1, 0, 0, 0, 16'h0030, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_1234) begin miscompares++; $display("FAIL prio_read: got %h expected 00001234", o_mem_data); end
        drive(1, 0, 0, 0, 0, 16'h0030, 32'hFFFF_FFFF); tick();
        vectors++; if (o_valid !== 1'b1 || o_mem_data !== 32'h0) begin
            miscompares++; $display("FAIL nonmem: got valid=%b data=%h expected 1 0", o_valid, o_mem_data); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
    endtask

    task automatic test_wrap();
        drive(1, 1, 0, 1, 0, 16'h0, 32'h0); tick();
        vectors++; if (o_sp !== 11'd0 || o_stack_wrap !== 1'b1) begin
            miscompares++; $display("FAIL wrap_pop: got sp=%0d wrap=%b expected 0 1", o_sp, o_stack_wrap); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
        vectors++; if (o_stack_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_pulse1: got %b expected 0", o_stack_wrap); end
        drive(1, 0, 1, 1, 0, 16'h0, 32'h0000_4444); tick();
        vectors++; if (o_sp !== 11'd2047 || o_stack_wrap !== 1'b1) begin
            miscompares++; $display("FAIL wrap_push: got sp=%0d wrap=%b expected 2047 1", o_sp, o_stack_wrap); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
        vectors++; if (o_stack_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_pulse2: got %b expected 0", o_stack_wrap); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, 0, 0, 16'd99, 32'h0000_5555); tick();
        drive(1, 0, 1, 0, 0, 16'd100, 32'h0000_7777); tick();
        drive(1, 1, 0, 1, 0, 16'h0, 32'h0);
        repeat (101) tick();
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
        vectors++; if (o_sp !== 11'd100) begin miscompares++; $display("FAIL mid_setup_sp: got %0d expected 100", o_sp); end
        drive(1, 0, 1, 1, 1, 16'h0, 32'hAAAA_BBBB); tick();
        rst = 1'b1;
        #1;
        vectors++; if (o_stall !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stall: got %b expected 0", o_stall); end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0);
        #1;
        vectors++; if (o_sp !== 11'd2047 || o_valid !== 1'b0 || o_stall !== 1'b0) begin
            miscompares++; $display("FAIL mid_after: got sp=%0d valid=%b stall=%b expected 2047 0 0", o_sp, o_valid, o_stall); end
        drive(1, 1, 0, 0, 0, 16'd100, 32'h0); tick();
        vectors++; if (o_valid !== 1'b1 || o_mem_data !== 32'h0000_AAAA) begin
            miscompares++; $display("FAIL mid_mem100: got valid=%b data=%h expected 1 0000aaaa", o_valid, o_mem_data); end
        drive(1, 1, 0, 0, 0, 16'd99, 32'h0); tick();
        vectors++; if (o_mem_data !== 32'h0000_5555) begin miscompares++; $display("FAIL mid_mem99: got %h expected 00005555", o_mem_data); end
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0); tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 16'h0, 32'h0);
        test_reset();
        test_push16();
        test_roundtrip();
        test_push32_pop32();
        test_nonstack();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
